// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);
    localparam int unsigned REG_ZERO  = 0;

    typedef logic [AW_DEF-1:0]   rf_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Decode/writeback bus of the register file: read, write, allocate and scoreboard signals.
interface regfile_mp_sb_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2
) ();
    localparam int unsigned AW = $clog2(NREGS);

    logic                 flush;
    logic [NRD*AW-1:0]    ra;
    logic [NRD*XLEN-1:0]  rd;
    logic [NRD-1:0]       rd_rdy;
    logic [NWR-1:0]       we;
    logic [NWR*AW-1:0]    wa;
    logic [NWR*XLEN-1:0]  wd;
    logic                 alloc_en;
    logic [AW-1:0]        alloc_a;
    logic [AW:0]          busy_cnt;

    modport master (
        output flush, ra, we, wa, wd, alloc_en, alloc_a,
        input  rd, rd_rdy, busy_cnt
    );

    modport slave (
        input  flush, ra, we, wa, wd, alloc_en, alloc_a,
        output rd, rd_rdy, busy_cnt
    );

endinterface

// File: rtl/rf_wr_arbiter.sv
// Picks the highest-index write port whose address matches i_addr.
module rf_wr_arbiter #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned NWR  = 2
) (
    input  logic [NWR-1:0]      i_we,
    input  logic [NWR*AW-1:0]   i_wa,
    input  logic [NWR*XLEN-1:0] i_wd,
    input  logic [AW-1:0]       i_addr,
    output logic                o_hit,
    output logic [XLEN-1:0]     o_sel_data
);

    // Later iterations override earlier ones, so the highest index wins.
    always_comb begin
        o_hit      = 1'b0;
        o_sel_data = '0;
        for (int p = 0; p < NWR; p++) begin
            if (i_we[p] && (i_wa[p*AW +: AW] == i_addr)) begin
                o_hit      = 1'b1;
                o_sel_data = i_wd[p*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-to-read bypass and per-register busy scoreboard.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 2,
    parameter bit          BYPASS = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    regfile_mp_sb_if.slave  bus
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0] r_mem [NREGS-1:1];
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_d;
    logic [AW:0]      r_busy_cnt;
    logic [AW:0]      w_busy_cnt_d;
    logic             w_wr_hit  [NREGS-1:1];
    logic [XLEN-1:0]  w_wr_data [NREGS-1:1];

    // Register 0 has no storage and no arbiter.
    for (genvar r = 1; r < NREGS; r++) begin : g_wr_arb
        rf_wr_arbiter #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_arb (
            .i_we      (bus.we),
            .i_wa      (bus.wa),
            .i_wd      (bus.wd),
            .i_addr    (AW'(r)),
            .o_hit     (w_wr_hit[r]),
            .o_sel_data(w_wr_data[r])
        );
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int r = 1; r < NREGS; r++) r_mem[r] <= '0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (w_wr_hit[r]) r_mem[r] <= w_wr_data[r];
            end
        end
    end

    // Flush beats allocate, allocate beats release.
    always_comb begin
        w_busy_d           = r_busy;
        w_busy_d[REG_ZERO] = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            if (bus.flush) begin
                w_busy_d[r] = 1'b0;
            end else if (bus.alloc_en && (bus.alloc_a == AW'(r))) begin
                w_busy_d[r] = 1'b1;
            end else if (w_wr_hit[r]) begin
                w_busy_d[r] = 1'b0;
            end
        end
    end

    always_comb begin
        w_busy_cnt_d = '0;
        for (int r = 1; r < NREGS; r++) begin
            w_busy_cnt_d = w_busy_cnt_d + (AW+1)'(w_busy_d[r]);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_d;
            r_busy_cnt <= w_busy_cnt_d;
        end
    end

    assign bus.busy_cnt = r_busy_cnt;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic            w_bp_hit;
        logic [XLEN-1:0] w_bp_data;
        logic [XLEN-1:0] w_rd;
        logic            w_rdy;

        assign w_ra = bus.ra[i*AW +: AW];

        if (BYPASS) begin : g_bp
            logic w_arb_hit;
            rf_wr_arbiter #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_bp_arb (
                .i_we      (bus.we),
                .i_wa      (bus.wa),
                .i_wd      (bus.wd),
                .i_addr    (w_ra),
                .o_hit     (w_arb_hit),
                .o_sel_data(w_bp_data)
            );
            // Writes are discarded under reset, so they must not forward either.
            assign w_bp_hit = w_arb_hit && !i_reset;
        end else begin : g_no_bp
            assign w_bp_hit  = 1'b0;
            assign w_bp_data = '0;
        end

        always_comb begin
            w_rd  = '0;
            w_rdy = 1'b1;
            if (w_ra == AW'(REG_ZERO)) begin
                w_rd  = '0;
                w_rdy = 1'b1;
            end else if (w_bp_hit) begin
                w_rd  = w_bp_data;
                w_rdy = 1'b1;
            end else begin
                w_rd  = r_mem[w_ra];
                w_rdy = !r_busy[w_ra];
            end
        end

        assign bus.rd[i*XLEN +: XLEN] = w_rd;
        assign bus.rd_rdy[i]          = w_rdy;
    end

`ifndef SYNTHESIS
    a_rd_known: assert property (@(posedge i_clk) disable iff (i_reset) !$isunknown(bus.rd));
    a_cnt_range: assert property (@(posedge i_clk) disable iff (i_reset)
        r_busy_cnt <= (AW+1)'(NREGS-1));
`endif

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed self-checking bench for regfile_mp_sb with hand-computed expectations.
module tb_regfile_mp_sb;
    import regfile_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned NWR   = 2;
    localparam int unsigned AW    = 5;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    regfile_mp_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

    regfile_mp_sb #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1'b1)
    ) dut (
        .i_clk  (clk),
        .i_reset(reset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.flush    = 1'b0;
        bus.we       = '0;
        bus.wa       = '0;
        bus.wd       = '0;
        bus.alloc_en = 1'b0;
        bus.alloc_a  = '0;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bus.ra = {a1, a0};
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input xlen_t d);
        bus.we[p]            = 1'b1;
        bus.wa[p*AW +: AW]   = a;
        bus.wd[p*XLEN +: XLEN] = d;
    endtask

    task automatic alloc(input logic [AW-1:0] a);
        bus.alloc_en = 1'b1;
        bus.alloc_a  = a;
    endtask

    // Each step: drive on the falling edge, settle, then sample.
    task automatic step();
        @(negedge clk);
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        idle();
        set_ra(5'd0, 5'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // T2: write with same-cycle bypass, then plain read
        step(); wr(0, 5'd5, 32'hDEADBEEF); set_ra(5'd5, 5'd0); #1;
        chk("t2_bypass_rd0", 64'(bus.rd[31:0]), 64'hDEADBEEF);
        chk("t2_bypass_rdy0", 64'(bus.rd_rdy[0]), 64'd1);
        step(); set_ra(5'd0, 5'd5); #1;
        chk("t2_plain_rd1", 64'(bus.rd[63:32]), 64'hDEADBEEF);

        // T3: x0 ignores writes and allocations
        step(); wr(1, 5'd0, 32'hFFFFFFFF); alloc(5'd0); set_ra(5'd0, 5'd0); #1;
        chk("t3_x0_bypass", 64'(bus.rd[31:0]), 64'd0);
        step(); #1;
        chk("t3_x0_stored", 64'(bus.rd[31:0]), 64'd0);
        chk("t3_x0_rdy", 64'(bus.rd_rdy[0]), 64'd1);
        chk("t3_busy_cnt", 64'(bus.busy_cnt), 64'd0);

        // T4: both ports write register 7, port 1 wins
        step(); wr(0, 5'd7, 32'd1); wr(1, 5'd7, 32'd2); set_ra(5'd7, 5'd0); #1;
        chk("t4_bypass_win", 64'(bus.rd[31:0]), 64'd2);
        step(); set_ra(5'd7, 5'd5); #1;
        chk("t4_stored_win", 64'(bus.rd[31:0]), 64'd2);
        chk("t4_other_reg", 64'(bus.rd[63:32]), 64'hDEADBEEF);

        // T5: scoreboard allocate / release
        step(); alloc(5'd9); set_ra(5'd9, 5'd0);
        step(); #1;
        chk("t5_rdy_busy", 64'(bus.rd_rdy[0]), 64'd0);
        chk("t5_cnt_one", 64'(bus.busy_cnt), 64'd1);
        step(); wr(0, 5'd9, 32'h99); alloc(5'd9); #1;
        chk("t5_bp_rdy", 64'(bus.rd_rdy[0]), 64'd1);
        chk("t5_bp_data", 64'(bus.rd[31:0]), 64'h99);
        step(); #1;
        chk("t5_realloc_rdy", 64'(bus.rd_rdy[0]), 64'd0);
        chk("t5_realloc_cnt", 64'(bus.busy_cnt), 64'd1);
        chk("t5_realloc_data", 64'(bus.rd[31:0]), 64'h99);
        step(); wr(1, 5'd9, 32'h123);
        step(); #1;
        chk("t5_release_cnt", 64'(bus.busy_cnt), 64'd0);
        chk("t5_release_rdy", 64'(bus.rd_rdy[0]), 64'd1);
        chk("t5_release_data", 64'(bus.rd[31:0]), 64'h123);

        // T6: flush clears busy, same-cycle write still commits
        step(); alloc(5'd3);
        step(); alloc(5'd4);
        step(); alloc(5'd5);
        step(); #1;
        chk("t6_cnt_three", 64'(bus.busy_cnt), 64'd3);
        bus.flush = 1'b1; wr(0, 5'd4, 32'd44); alloc(5'd6);
        step(); set_ra(5'd4, 5'd3); #1;
        chk("t6_flush_cnt", 64'(bus.busy_cnt), 64'd0);
        chk("t6_flush_data", 64'(bus.rd[31:0]), 64'd44);
        chk("t6_flush_rdy", 64'(bus.rd_rdy), 64'b11);

        // T1: asynchronous reset mid-traffic
        step(); alloc(5'd10);
        step(); wr(0, 5'd11, 32'hCAFE); alloc(5'd12); set_ra(5'd11, 5'd5); #1;
        chk("t1_pre_cnt", 64'(bus.busy_cnt), 64'd1);
        chk("t1_pre_bypass", 64'(bus.rd[31:0]), 64'hCAFE);
        #1 reset = 1'b1;
        #1;
        chk("t1_rst_rd", 64'(bus.rd), 64'd0);
        chk("t1_rst_rdy", 64'(bus.rd_rdy), 64'b11);
        chk("t1_rst_cnt", 64'(bus.busy_cnt), 64'd0);
        step(); reset = 1'b0; set_ra(5'd11, 5'd4); #1;
        chk("t1_post_rd", 64'(bus.rd), 64'd0);
        chk("t1_post_cnt", 64'(bus.busy_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
